scale_pipe: RTL and testbench

//  Parametrised, registered successor to the IF->ID constant-scaling chain.

---
 rtl/scale_pipe_pkg.sv | 21 ++
 rtl/scale_pipe_stage.sv | 63 ++++++
 rtl/scale_pipe.sv | 81 ++++++++
 tb/tb_scale_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pipe_pkg.sv
// Shared types, defaults and coefficient lookup for the scale_pipe block.
package scale_pipe_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 2;
  localparam int unsigned COEF_W     = 32;
  localparam int unsigned MAX_STAGES = 16;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [MAX_STAGES*COEF_W-1:0] coef_vec_t;

  // Default coefficients: fetch-side stage scales by 22, decode-side by 3.
  localparam coef_t C_IF = 32'd22;
  localparam coef_t C_ID = 32'd3;

  // Coefficient of stage idx from a packed coefficient vector (slice 0 = stage 0).
  function automatic coef_t coef_at(input coef_vec_t coefs, input int unsigned idx);
    return coefs[idx*COEF_W +: COEF_W];
  endfunction

endpackage

// File: rtl/scale_pipe_stage.sv
// One pipeline slice of scale_pipe: valid/data(/ovf) registers, constant
// multiply with truncation, and this slice's ready term.
// SCALE_PIPE_OVF_EN: when defined, an overflow flag travels with each item.
module scale_stage
  import scale_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter coef_t       COEF  = C_IF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_ovf,
  input  logic             next_ready,
  output logic             rdy_c,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ovf
);

  localparam int unsigned PROD_W = WIDTH + COEF_W;

  logic [PROD_W-1:0] prod_c;

  // Full-width product; the low WIDTH bits are the stage result.
  assign prod_c = PROD_W'(prev_data) * PROD_W'(COEF);

  // Slice can take a new item when empty or when its item moves on.
  assign rdy_c = ~valid | next_ready;

  // Valid/data register: flush empties the slice, otherwise load when ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy_c) begin
      valid <= prev_valid;
      data  <= prod_c[WIDTH-1:0];
    end
  end

`ifdef SCALE_PIPE_OVF_EN
  // Sticky overflow flag accompanying the item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (!flush && rdy_c) begin
      ovf <= prev_ovf | (|prod_c[PROD_W-1:WIDTH]);
    end
  end
`else
  logic unused_ovf;

  // No overflow tracking in this build.
  assign ovf        = 1'b0;
  assign unused_ovf = prev_ovf | (|prod_c[PROD_W-1:WIDTH]);
`endif

endmodule

// File: rtl/scale_pipe.sv
// scale_pipe: STAGES-deep valid/ready pipeline, each stage multiplying by its
// own constant coefficient (results mod 2^WIDTH).
// SCALE_PIPE_OVF_EN: when defined, out_ovf reports overflow in any stage.
module scale_pipe
  import scale_pipe_pkg::*;
#(
  parameter int unsigned         WIDTH  = DEF_WIDTH,
  parameter int unsigned         STAGES = DEF_STAGES,
  parameter logic [STAGES*32-1:0] COEFS = {C_ID, C_IF}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam coef_vec_t COEF_VEC = coef_vec_t'(COEFS);

  logic             rdy [STAGES+1];
  logic             v   [STAGES];
  logic [WIDTH-1:0] d   [STAGES];
  logic             o   [STAGES];

  // Ready chain terminates at the downstream ready; flush blocks new input.
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0] & ~flush;

  // Chain the stages: stage 0 takes the port, stage i takes stage i-1.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    logic             po;

    if (gi == 0) begin : g_head
      assign pv = in_valid & in_ready;
      assign pd = in_data;
      assign po = 1'b0;
    end else begin : g_body
      assign pv = v[gi-1];
      assign pd = d[gi-1];
      assign po = o[gi-1];
    end

    scale_stage #(
      .WIDTH (WIDTH),
      .COEF  (coef_at(COEF_VEC, gi))
    ) u_stage (
      .clk        (clock),
      .rst_n      (reset),
      .flush      (flush),
      .prev_valid (pv),
      .prev_data  (pd),
      .prev_ovf   (po),
      .next_ready (rdy[gi+1]),
      .rdy_c      (rdy[gi]),
      .valid      (v[gi]),
      .data       (d[gi]),
      .ovf        (o[gi])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign out_ovf   = o[STAGES-1];

  // Busy whenever any stage holds an item.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      busy = busy | v[i];
    end
  end

endmodule

// File: tb/tb_scale_pipe.sv
// Scoreboard bench for scale_pipe (default WIDTH=32, STAGES=2, coefs 22 then 3).
module tb_scale_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    int          due;
  } exp_t;

`ifdef SCALE_PIPE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        busy;

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  exp_t sb[$];

  scale_pipe u_dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference: multiply by 22 then by 3, each mod 2^32, flag any high bits.
  function automatic logic [32:0] model(input logic [31:0] x);
    longint unsigned p0, p1;
    logic ov;
    p0 = 64'(x) * 64'd22;
    ov = (p0 >> 32) != 0;
    p1 = (p0 & 64'hFFFF_FFFF) * 64'd3;
    ov = ov | ((p1 >> 32) != 0);
    return {ov & OVF_ON, p1[31:0]};
  endfunction

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_data, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_ovf", 32'(out_ovf), 32'(e.o));
        if (e.due >= 0) check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Offer x until accepted; expected result queued at acceptance.
  task automatic push(input logic [31:0] x, input logic [31:0] ed, input logic eo,
                      input bit timed, input bit rnd_rdy);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clock);
      if (in_ready) begin
        exp_t e;
        e.d = ed;
        e.o = eo & OVF_ON;
        e.due = timed ? cyc + 2 : -1;
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clock);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(posedge clock);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] x;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'd5; out_ready = 1'b1;

    // Reset holds everything empty even with input offered.
    repeat (2) @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Single item and back-to-back items, unstalled, timed.
    push(32'd1, 32'd66, 1'b0, 1'b1, 1'b0);
    idle(4);
    push(32'd1, 32'd66, 1'b0, 1'b1, 1'b0);
    push(32'd2, 32'd132, 1'b0, 1'b1, 1'b0);
    push(32'd3, 32'd198, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Wrap-around.
    push(32'hFFFF_FFFF, 32'hFFFF_FFBE, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Fill with downstream stalled, then release.
    out_ready = 1'b0;
    push(32'd5, 32'd330, 1'b0, 1'b0, 1'b0);
    push(32'd6, 32'd396, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'd7;
    @(negedge clock);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("stall_hold_valid", 32'(out_valid), 32'd1);
    check("stall_hold_data", out_data, 32'd330);
    @(posedge clock);
    #1 out_ready = 1'b1;
    push(32'd7, 32'd462, 1'b0, 1'b0, 1'b0);
    drain();

    // Flush two in-flight items while offering a third.
    out_ready = 1'b0;
    push(32'd10, 32'd660, 1'b0, 1'b0, 1'b0);
    push(32'd11, 32'd726, 1'b0, 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd99;
    @(negedge clock);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_still_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1 flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    idle(5);

    // Asynchronous reset mid-operation discards everything.
    out_ready = 1'b0;
    push(32'd20, 32'd1320, 1'b0, 1'b0, 1'b0);
    push(32'd21, 32'd1386, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_data", out_data, 32'd0);
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b1; out_ready = 1'b1;
    idle(3);

    // Overflow in stage 0 only, then a clean item.
    push(32'h0C00_0000, 32'h1800_0000, 1'b1, 1'b1, 1'b0);
    push(32'd2, 32'd132, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Randomised traffic with random downstream back-pressure.
    for (int k = 0; k < 300; k++) begin
      idle($urandom_range(0, 2));
      out_ready = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1000));
      m = model(x);
      push(x, m[31:0], m[32], 1'b0, 1'b1);
    end
    drain();
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
